// File: rtl/ic_test_if.sv
// ic_test_if
// Bundles the control handshake and the tester-socket pins of the
// quad 2-input gate IC tester.
//
// Handshake:
//   - start is a level request. The sequencer accepts it only on a clock edge
//     where the sequencer is idle. A request seen while busy or in the verdict
//     cycle is dropped and is not queued.
//   - busy is high from the accepting edge until the verdict cycle has been left.
//   - done is a one-cycle strobe. It qualifies pass and fail_mask.
//   - pass and fail_mask keep their value until the next accepted start.
//
// Signals:
//   start, ic_sel     request and device type (0 NAND, 1 AND, 2 OR, 3 XOR)
//   dut_a, dut_b      A/B pins of gates 0..3, driven by the sequencer
//   dut_y             Y pins of gates 0..3, asynchronous, driven by the socket
//   busy, done, pass  status and verdict
//   fail_mask         bit g is set if gate g mismatched on any vector
//
// Modports:
//   master  requester plus socket side
//   slave   sequencer side
interface ic_test_if;
    logic       start;
    logic [1:0] ic_sel;
    logic [3:0] dut_a;
    logic [3:0] dut_b;
    logic [3:0] dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;

    modport master (
        output start, ic_sel, dut_y,
        input  dut_a, dut_b, busy, done, pass, fail_mask
    );

    modport slave (
        input  start, ic_sel, dut_y,
        output dut_a, dut_b, busy, done, pass, fail_mask
    );
endinterface

// File: rtl/ic_test_sequencer.sv
// ic_test_sequencer
// Exhaustively exercises a quad 2-input gate IC (7400/7408/7432/7486).
// The same A/B vector is applied to all four gates in the order
// 00, 01, 10, 11. Each vector is held for SETTLE_CYCLES cycles. The
// synchronised Y pins are then compared with the truth table of the latched
// device type. Mismatches accumulate per gate into fail_mask. The verdict
// (pass) is published with a one-cycle done strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset; aborts a test without a done
//   bus        ic_test_if.slave (start/ic_sel in, dut pins, verdict out)
//   dbg_state  current FSM state (IDLE=0 APPLY=1 SETTLE=2 SAMPLE=3 DONE=4)
//
// Parameter:
//   SETTLE_CYCLES  hold time per vector before sampling, legal range 3..255.
//                  It must cover the pin propagation time plus the 2-FF
//                  synchroniser.
module ic_test_sequencer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    ic_test_if.slave    bus,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] settle_q, settle_d;
    logic [3:0] dut_a_q, dut_a_d;
    logic [3:0] dut_b_q, dut_b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] expected;
    logic [3:0] mismatch;

    // Truth table of one gate for a given device type.
    function automatic logic gate_ref(input logic [1:0] kind, input logic a, input logic b);
        case (kind)
            2'd0:    return ~(a & b);
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // The pins still carry vec_q during SAMPLE, so vec_q gives the A/B values
    // that belong to the synchronised Y.
    assign expected = {4{gate_ref(sel_q, vec_q[1], vec_q[0])}};
    assign mismatch = sync2_q ^ expected;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_APPLY;
            S_APPLY:  state_d = S_SETTLE;
            S_SETTLE: if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
            S_SAMPLE: state_d = (vec_q == 2'd3) ? S_DONE : S_APPLY;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and datapath.
    // done and the final pass are computed on the SAMPLE->DONE transition.
    // Both are therefore valid while the FSM sits in DONE.
    always_comb begin
        sel_d    = sel_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        dut_a_d  = dut_a_q;
        dut_b_d  = dut_b_q;
        pass_d   = pass_q;
        mask_d   = mask_q;
        done_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                dut_a_d = 4'h0;
                dut_b_d = 4'h0;
                if (bus.start) begin
                    sel_d  = bus.ic_sel;
                    vec_d  = 2'd0;
                    pass_d = 1'b0;
                    mask_d = 4'h0;
                end
            end
            S_APPLY: begin
                dut_a_d  = {4{vec_q[1]}};
                dut_b_d  = {4{vec_q[0]}};
                settle_d = 8'd0;
            end
            S_SETTLE: begin
                if (settle_q != SETTLE_MAX) settle_d = settle_q + 8'd1;
            end
            S_SAMPLE: begin
                mask_d = mask_q | mismatch;
                if (vec_q == 2'd3) begin
                    pass_d  = ((mask_q | mismatch) == 4'h0);
                    done_d  = 1'b1;
                    dut_a_d = 4'h0;
                    dut_b_d = 4'h0;
                end else begin
                    vec_d = vec_q + 2'd1;
                end
            end
            S_DONE: begin
                dut_a_d = 4'h0;
                dut_b_d = 4'h0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= 2'd0;
            vec_q    <= 2'd0;
            settle_q <= 8'd0;
            dut_a_q  <= 4'h0;
            dut_b_q  <= 4'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            mask_q   <= 4'h0;
            sync1_q  <= 4'h0;
            sync2_q  <= 4'h0;
        end else begin
            sel_q    <= sel_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            dut_a_q  <= dut_a_d;
            dut_b_q  <= dut_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            mask_q   <= mask_d;
            sync1_q  <= bus.dut_y;
            sync2_q  <= sync1_q;
        end
    end

    assign bus.dut_a     = dut_a_q;
    assign bus.dut_b     = dut_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = mask_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ic_test_sequencer.sv
// tb_ic_test_sequencer
// Drives ic_test_sequencer through directed and randomised tests against a
// simulated socket. The socket is configured with a device type and
// stuck-at-0/1 faults per gate. Expected pins, fail_mask, pass, done and busy
// come from an edge-count model of the test: each vector takes
// SETTLE_CYCLES+2 cycles, and the mismatches per vector come from the truth
// tables.
module tb_ic_test_sequencer;

    localparam int S   = 4;
    localparam int VEC = S + 2;       // cycles per vector
    localparam int LAT = 4 * VEC;     // acceptance edge to done edge

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    ic_test_if ic ();

    ic_test_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ic),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // socket model configuration
    logic [1:0] dev_kind = 2'd0;
    logic [3:0] stuck0   = 4'h0;
    logic [3:0] stuck1   = 4'h0;

    function automatic logic gate_fn(input logic [1:0] kind, input logic a, input logic b);
        case (kind)
            2'd0:    return ~(a & b);
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb begin
        for (int g = 0; g < 4; g++)
            ic.dut_y[g] = (gate_fn(dev_kind, ic.dut_a[g], ic.dut_b[g]) | stuck1[g]) & ~stuck0[g];
    end

    // Reference: per-gate mismatch of the socket against the selected truth table
    // for vector v (A = v[1], B = v[0]).
    function automatic logic [3:0] vector_err(input int v, input logic [1:0] sel,
                                              input logic [1:0] dev, input logic [3:0] s0,
                                              input logic [3:0] s1);
        logic [3:0] e;
        logic       a, b, y;
        a = (v / 2) % 2 == 1;
        b = v % 2 == 1;
        for (int g = 0; g < 4; g++) begin
            y    = (gate_fn(dev, a, b) | s1[g]) & ~s0[g];
            e[g] = y ^ gate_fn(sel, a, b);
        end
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver: one full test; if meddle is set, start and ic_sel are scrambled mid-test
    task automatic run_test(input logic [1:0] sel, input logic [1:0] dev,
                            input logic [3:0] s0, input logic [3:0] s1, input bit meddle);
        logic [3:0] part;
        logic [3:0] final_mask;
        logic [3:0] pin_v;
        int         v;
        dev_kind = dev;
        stuck0   = s0;
        stuck1   = s1;
        final_mask = 4'h0;
        for (int i = 0; i < 4; i++) final_mask |= vector_err(i, sel, dev, s0, s1);
        @(negedge clk);
        ic.ic_sel = sel;
        ic.start  = 1'b1;
        @(posedge clk);               // acceptance edge 0
        #1 ic.start = 1'b0;
        @(negedge clk);
        check_eq("busy_accept", ic.busy, 1'b1);
        check_eq("pass_clear", ic.pass, 1'b0);
        check_eq("mask_clear", ic.fail_mask, 4'h0);
        for (int k = 1; k <= LAT + 4; k++) begin
            if (meddle && k <= LAT) begin
                ic.start  = 1'($urandom_range(0, 1));
                ic.ic_sel = 2'($urandom_range(0, 3));
            end else begin
                ic.start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            part = 4'h0;
            for (int i = 0; i < 4; i++)
                if ((i + 1) * VEC <= k) part |= vector_err(i, sel, dev, s0, s1);
            check_eq("fail_mask", ic.fail_mask, part);
            check_eq("done", ic.done, k == LAT);
            if (k >= LAT) check_eq("pass", ic.pass, final_mask == 4'h0);
            else          check_eq("pass_hold0", ic.pass, 1'b0);
            if (k < LAT)  check_eq("busy", ic.busy, 1'b1);
            if (k > LAT)  check_eq("busy_idle", ic.busy, 1'b0);
            if (k >= 1 && k < LAT) begin
                v     = (k - 1) / VEC;
                pin_v = {4{v >= 2}};
                check_eq("dut_a", ic.dut_a, pin_v);
                pin_v = {4{(v % 2) == 1}};
                check_eq("dut_b", ic.dut_b, pin_v);
            end
            if (k > LAT) begin
                check_eq("dut_a_idle", ic.dut_a, 4'h0);
                check_eq("dut_b_idle", ic.dut_b, 4'h0);
            end
        end
    endtask

    int  done_cnt;
    logic [1:0] r_sel, r_dev;
    logic [3:0] r_s0, r_s1;

    initial begin
        rst       = 1'b1;
        ic.start  = 1'b0;
        ic.ic_sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", ic.busy, 1'b0);
        check_eq("rst_done", ic.done, 1'b0);
        check_eq("rst_pass", ic.pass, 1'b0);
        check_eq("rst_mask", ic.fail_mask, 4'h0);
        check_eq("rst_dut_a", ic.dut_a, 4'h0);
        check_eq("rst_dut_b", ic.dut_b, 4'h0);
        rst = 1'b0;

        // directed cases
        run_test(2'd0, 2'd0, 4'h0, 4'h0, 1'b0);   // good NAND
        run_test(2'd1, 2'd1, 4'h4, 4'h0, 1'b0);   // AND, gate 2 stuck at 0
        run_test(2'd3, 2'd2, 4'h0, 4'h0, 1'b0);   // OR device tested as XOR
        run_test(2'd0, 2'd0, 4'h0, 4'h0, 1'b1);   // start/ic_sel scrambled mid-test

        // reset during the second vector's SETTLE
        run_test(2'd2, 2'd2, 4'h0, 4'h0, 1'b0);   // leaves pass=1 behind
        @(negedge clk);
        ic.ic_sel = 2'd1;
        dev_kind  = 2'd1;
        ic.start  = 1'b1;
        @(posedge clk);
        #1 ic.start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_busy", ic.busy, 1'b0);
        check_eq("abort_done", ic.done, 1'b0);
        check_eq("abort_pass", ic.pass, 1'b0);
        check_eq("abort_mask", ic.fail_mask, 4'h0);
        check_eq("abort_dut_a", ic.dut_a, 4'h0);
        check_eq("abort_dut_b", ic.dut_b, 4'h0);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ic.done) done_cnt++;
        end
        check_eq("abort_no_done", done_cnt, 0);
        run_test(2'd1, 2'd1, 4'h0, 4'h0, 1'b0);

        // start held high across two back-to-back tests, good OR
        dev_kind = 2'd2;
        stuck0   = 4'h0;
        stuck1   = 4'h0;
        @(negedge clk);
        ic.ic_sel = 2'd2;
        ic.start  = 1'b1;
        @(posedge clk);                           // acceptance edge 0
        for (int k = 1; k <= 2 * LAT + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("held_done", ic.done, (k == LAT) || (k == 2 * LAT + 2));
            check_eq("held_pass", ic.pass,
                     ((k >= LAT) && (k < LAT + 2)) || (k >= 2 * LAT + 2));
            if (k == LAT + 2) check_eq("held_busy_reaccept", ic.busy, 1'b1);
        end
        ic.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("held_idle_busy", ic.busy, 1'b0);

        // randomised tests
        for (int i = 0; i < 10; i++) begin
            r_sel = 2'($urandom_range(0, 3));
            r_dev = ($urandom_range(0, 1) == 1) ? r_sel : 2'($urandom_range(0, 3));
            r_s0  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            r_s1  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            run_test(r_sel, r_dev, r_s0, r_s1, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
